// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared owner-state enum and starvation counter width for the SRAM port arbiter
package sram_arb_pkg;

  localparam int STARVE_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    INST_RD = 2'd1,
    DATA_RD = 2'd2,
    DATA_WR = 2'd3
  } owner_e;

endpackage

// File: rtl/sram_arb_prio.sv
// rtl/sram_arb_prio.sv - data-first fixed priority with a force-inst override, purely combinational
module sram_arb_prio (
  input  logic inst_req,
  input  logic data_req,
  input  logic force_inst,
  output logic inst_gnt,
  output logic data_gnt
);

  // Data wins unless fetch has waited long enough and is still asking.
  always_comb begin
    inst_gnt = 1'b0;
    data_gnt = 1'b0;
    if (data_req && !(inst_req && force_inst)) begin
      data_gnt = 1'b1;
    end else if (inst_req) begin
      inst_gnt = 1'b1;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - shares one 1-cycle-latency SRAM between fetch and data ports; SRAM_ARB_PERF_CNT_EN adds perf counters
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_gnt,
  output logic                inst_rvalid,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic [DATA_W/8-1:0] data_wen,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_gnt,
  output logic                data_rvalid,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_wen,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
`ifdef SRAM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]         perf_inst_gnt,
  output logic [31:0]         perf_data_gnt,
  output logic [31:0]         perf_conflict
`endif
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  owner_e              state_q, state_d;
  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
  logic                inst_req_v, data_req_v, force_inst;

  // Requests are masked during reset so no grant or SRAM access can leak out.
  assign inst_req_v = inst_req & ~rst;
  assign data_req_v = data_req & ~rst;
  assign force_inst = (starve_cnt_q == LIMIT);

  sram_arb_prio u_prio (
    .inst_req   (inst_req_v),
    .data_req   (data_req_v),
    .force_inst (force_inst),
    .inst_gnt   (inst_gnt),
    .data_gnt   (data_gnt)
  );

  // Drive the SRAM with the winner's fields; write fields only ever come from the data port.
  always_comb begin
    mem_en    = inst_gnt | data_gnt;
    mem_wen   = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (inst_gnt) begin
      mem_addr = inst_addr;
    end else if (data_gnt) begin
      mem_addr  = data_addr;
      mem_wen   = data_wen;
      mem_wdata = data_wdata;
    end
  end

  // Count data grants that overtook a waiting fetch; saturate at the limit.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (inst_gnt) begin
      starve_cnt_d = '0;
    end else if (data_gnt && inst_req && (starve_cnt_q != LIMIT)) begin
      starve_cnt_d = starve_cnt_q + STARVE_W'(1);
    end
  end

  // Remember what this cycle's access was so its read data can be routed next cycle.
  always_comb begin
    state_d = IDLE;
    if (inst_gnt) begin
      state_d = INST_RD;
    end else if (data_gnt) begin
      state_d = (data_wen == '0) ? DATA_RD : DATA_WR;
    end
  end

  // Owner state and starvation counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // A read in flight when reset arrives is dropped rather than returned.
  assign inst_rvalid = (state_q == INST_RD) && !rst;
  assign data_rvalid = (state_q == DATA_RD) && !rst;
  assign inst_rdata  = mem_rdata;
  assign data_rdata  = mem_rdata;

`ifdef SRAM_ARB_PERF_CNT_EN
  logic [31:0] perf_inst_gnt_q, perf_inst_gnt_d;
  logic [31:0] perf_data_gnt_q, perf_data_gnt_d;
  logic [31:0] perf_conflict_q, perf_conflict_d;

  // Free-running event counters that wrap naturally.
  always_comb begin
    perf_inst_gnt_d = perf_inst_gnt_q + {31'd0, inst_gnt};
    perf_data_gnt_d = perf_data_gnt_q + {31'd0, data_gnt};
    perf_conflict_d = perf_conflict_q + {31'd0, inst_req_v & data_req_v};
  end

  // Perf counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_inst_gnt_q <= '0;
      perf_data_gnt_q <= '0;
      perf_conflict_q <= '0;
    end else begin
      perf_inst_gnt_q <= perf_inst_gnt_d;
      perf_data_gnt_q <= perf_data_gnt_d;
      perf_conflict_q <= perf_conflict_d;
    end
  end

  assign perf_inst_gnt = perf_inst_gnt_q;
  assign perf_data_gnt = perf_data_gnt_q;
  assign perf_conflict = perf_conflict_q;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - randomized self-checking bench for sram_port_arbiter against a behavioural model
module tb_sram_port_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_gnt, inst_rvalid;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic [3:0]  data_wen;
  logic [31:0] data_addr, data_wdata;
  logic        data_gnt, data_rvalid;
  logic [31:0] data_rdata;
  logic        mem_en;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef SRAM_ARB_PERF_CNT_EN
  logic [31:0] perf_inst_gnt, perf_data_gnt, perf_conflict;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Model: data grants that overtook a waiting fetch, and read returns owed next cycle.
  int   m_wait = 0;
  logic m_irv  = 1'b0;
  logic m_drv  = 1'b0;

  always #5 clk = ~clk;

  sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk         (clk),
    .rst         (rst),
    .inst_req    (inst_req),
    .inst_addr   (inst_addr),
    .inst_gnt    (inst_gnt),
    .inst_rvalid (inst_rvalid),
    .inst_rdata  (inst_rdata),
    .data_req    (data_req),
    .data_wen    (data_wen),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_gnt    (data_gnt),
    .data_rvalid (data_rvalid),
    .data_rdata  (data_rdata),
    .mem_en      (mem_en),
    .mem_wen     (mem_wen),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
`ifdef SRAM_ARB_PERF_CNT_EN
    ,
    .perf_inst_gnt (perf_inst_gnt),
    .perf_data_gnt (perf_data_gnt),
    .perf_conflict (perf_conflict)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive just after the rising edge, check at the falling edge, advance the model.
  task automatic step(input logic r, input logic ir, input logic [31:0] ia,
                      input logic dr, input logic [31:0] da, input logic [3:0] dw,
                      input logic [31:0] dd, output logic gi, output logic gd);
    logic [31:0] rd;
    #1;
    rst = r; inst_req = ir; inst_addr = ia;
    data_req = dr; data_addr = da; data_wen = dw; data_wdata = dd;
    rd = $urandom;
    mem_rdata = rd;
    #4;
    if (r) begin
      gi = 1'b0;
      gd = 1'b0;
    end else begin
      gd = dr && !(ir && m_wait >= LIMIT);
      gi = ir && !gd;
    end
    chk("inst_gnt", inst_gnt, gi);
    chk("data_gnt", data_gnt, gd);
    chk("mem_en", mem_en, gi | gd);
    chk("mem_wen", mem_wen, gd ? dw : 4'h0);
    chk("mem_wdata", mem_wdata, gd ? dd : 32'h0);
    if (gi)      chk("mem_addr_inst", mem_addr, ia);
    else if (gd) chk("mem_addr_data", mem_addr, da);
    else if (r)  chk("mem_addr_rst", mem_addr, 32'h0);
    chk("inst_rvalid", inst_rvalid, r ? 1'b0 : m_irv);
    chk("data_rvalid", data_rvalid, r ? 1'b0 : m_drv);
    if (!r && m_irv) chk("inst_rdata", inst_rdata, rd);
    if (!r && m_drv) chk("data_rdata", data_rdata, rd);
    if (r) begin
      m_wait = 0;
      m_irv  = 1'b0;
      m_drv  = 1'b0;
    end else begin
      m_irv = gi;
      m_drv = gd && (dw == 4'h0);
      if (gi) m_wait = 0;
      else if (gd && ir) m_wait++;
    end
    @(posedge clk);
  endtask

  logic        gi, gd;
  logic [9:0]  pat;
  logic        ip, dp;
  logic [31:0] ia, da, dd;
  logic [3:0]  dw;

  initial begin
    rst = 1'b1; inst_req = 1'b0; inst_addr = '0; data_req = 1'b0;
    data_addr = '0; data_wen = '0; data_wdata = '0; mem_rdata = '0;
    @(posedge clk);

    // Reset state, with requests present to show they are masked.
    step(1, 1, 32'h1234, 1, 32'h5678, 4'hf, 32'h1111, gi, gd);
    step(1, 0, 0, 0, 0, 0, 0, gi, gd);

    // Reset landing mid-read drops the return.
    step(0, 0, 0, 0, 0, 0, 0, gi, gd);
    step(0, 0, 0, 1, 32'h100, 4'h0, 32'h0, gi, gd);
    chk("rmr_gnt", gd, 1'b1);
    step(1, 0, 0, 0, 0, 0, 0, gi, gd);
    step(0, 0, 0, 0, 0, 0, 0, gi, gd);

    // Fetch alone, then its return.
    step(0, 1, 32'hbfc00000, 0, 0, 0, 0, gi, gd);
    step(0, 0, 0, 0, 0, 0, 0, gi, gd);

    // Conflict: data read wins.
    step(0, 1, 32'hbfc00004, 1, 32'h80, 4'h0, 32'h0, gi, gd);
    step(0, 1, 32'hbfc00004, 0, 0, 0, 0, gi, gd);
    step(0, 0, 0, 0, 0, 0, 0, gi, gd);

    // Partial write: no read return follows.
    step(0, 0, 0, 1, 32'h40, 4'b0011, 32'hdeadbeef, gi, gd);
    step(0, 0, 0, 0, 0, 0, 0, gi, gd);

    // Starvation and perf counters: ten conflict cycles straight out of reset.
    step(1, 0, 0, 0, 0, 0, 0, gi, gd);
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 32'h1000 + 32'(i), 1, 32'h2000 + 32'(i), 4'h0, 32'h0, gi, gd);
      pat[i] = data_gnt;
    end
    chk("starve_pattern", {54'd0, pat}, 64'b0111101111);
`ifdef SRAM_ARB_PERF_CNT_EN
    #5;
    chk("perf_conflict", perf_conflict, 32'd10);
    chk("perf_data_gnt", perf_data_gnt, 32'd8);
    chk("perf_inst_gnt", perf_inst_gnt, 32'd2);
    @(posedge clk);
`endif

    // Randomized traffic with protocol-respecting requesters and occasional reset.
    ip = 1'b0; dp = 1'b0; ia = '0; da = '0; dw = '0; dd = '0;
    for (int c = 0; c < 600; c++) begin
      if (!ip && ($urandom_range(0, 2) != 0)) begin
        ip = 1'b1;
        ia = $urandom;
      end
      if (!dp && ($urandom_range(0, 3) != 0)) begin
        dp = 1'b1;
        da = $urandom;
        dd = $urandom;
        dw = $urandom_range(0, 1) ? 4'h0 : 4'($urandom);
      end
      step(($urandom_range(0, 60) == 0), ip, ia, dp, da, dw, dd, gi, gd);
      if (gi) ip = 1'b0;
      if (gd) dp = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
